hyperram_ctrl: RTL and testbench

//  Single-word HyperBus (HyperRAM) master: one 32-bit read or masked write per transaction.

---
 rtl/hyperram_pkg.sv | 37 +++
 rtl/hyperram_ca_encode.sv | 27 ++
 rtl/hyperram_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_hyperram_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperram_pkg.sv
// ============================================================================
// hyperram_pkg
// Shared definitions for the single-word HyperBus master.
//   state_t      : one-hot controller states (7)
//   CA_*         : bit positions of the fields inside the 48-bit command/address
//   CA_BYTES     : command/address length on the bus, in bytes
//   DATA_BYTES   : data phase length, in bytes (one 32-bit word)
//   bus_active() : true for states that keep ck toggling
// ============================================================================
package hyperram_pkg;

    typedef enum logic [6:0] {
        ST_IDLE    = 7'b000_0001,
        ST_CA      = 7'b000_0010,
        ST_LATENCY = 7'b000_0100,
        ST_WDATA   = 7'b000_1000,
        ST_RDATA   = 7'b001_0000,
        ST_HOLD    = 7'b010_0000,
        ST_RECOVER = 7'b100_0000
    } state_t;

    localparam int unsigned CA_RW_BIT    = 47;
    localparam int unsigned CA_AS_BIT    = 46;
    localparam int unsigned CA_BURST_BIT = 45;
    localparam int unsigned CA_ROW_HI    = 44;
    localparam int unsigned CA_ROW_LO    = 16;
    localparam int unsigned CA_COL_HI    = 2;
    localparam int unsigned CA_COL_LO    = 0;

    localparam int unsigned CA_BYTES   = 6;
    localparam int unsigned DATA_BYTES = 4;

    function automatic logic bus_active(state_t s);
        return (s == ST_CA) || (s == ST_LATENCY) || (s == ST_WDATA) || (s == ST_RDATA);
    endfunction

endpackage

// File: rtl/hyperram_ca_encode.sv
// ============================================================================
// hyperram_ca_encode
// Combinational builder of the 48-bit HyperBus command/address word.
// Ports:
//   write_enable in  1   1=write, 0=read (CA bit 47 is its inverse)
//   address      in  32  word address; [31:3] row/upper, [2:0] column
//   ca           out 48  command/address, bit 47 goes on the bus first
// Memory space and linear burst are fixed.
// ============================================================================
module hyperram_ca_encode
    import hyperram_pkg::*;
(
    input  logic        write_enable,
    input  logic [31:0] address,
    output logic [47:0] ca
);

    always_comb begin
        ca                        = '0;
        ca[CA_RW_BIT]             = ~write_enable;
        ca[CA_AS_BIT]             = 1'b0;
        ca[CA_BURST_BIT]          = 1'b1;
        ca[CA_ROW_HI:CA_ROW_LO]   = address[31:3];
        ca[CA_COL_HI:CA_COL_LO]   = address[2:0];
    end

endmodule

// File: rtl/hyperram_ctrl.sv
// ============================================================================
// hyperram_ctrl
// Single-word HyperBus master: one 32-bit read or masked write per transaction.
// One bus byte per clk cycle; ck runs at clk/2 while chip select is active.
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   transaction_begin   start request, only honoured in IDLE
//   write_enable        1=write, 0=read            (latched at start)
//   address [31:0]      HyperRAM address           (latched at start)
//   write_mask [3:0]    byte enables, 1=write      (latched at start)
//   data_out [31:0]     write data                 (latched at start)
//   wait_latency [5:0]  clk cycles between CA and data
//   done_latency [5:0]  clk cycles of recovery after cs_n rises
//   timed_read          1=capture on fixed cycles, 0=capture on rwds edges
//   dq [7:0], rwds      HyperBus bidirectional pins
//   ck, cs_n            HyperBus clock and active-low chip select
//   data_in [31:0]      read data, valid with done after a read
//   busy, done          busy: not IDLE; done: 1-cycle pulse on return to IDLE
// Configuration:
//   HYPERRAM_FORMAL_EN  defined -> embedded assertions and covers
// ============================================================================
module hyperram_ctrl
    import hyperram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        transaction_begin,
    input  logic        write_enable,
    input  logic [31:0] address,
    input  logic [3:0]  write_mask,
    input  logic [31:0] data_out,
    input  logic [5:0]  wait_latency,
    input  logic [5:0]  done_latency,
    input  logic        timed_read,
    inout  wire  [7:0]  dq,
    inout  wire         rwds,
    output logic        ck,
    output logic        cs_n,
    output logic [31:0] data_in,
    output logic        busy,
    output logic        done
);

    state_t      state, next_state;

    logic [47:0] ca_word;
    logic [47:0] ca_shift;
    logic [31:0] wdata_shift;
    logic [3:0]  mask_shift;
    logic [31:0] rdata_shift;
    logic        we_q;
    logic        ck_q;
    logic        rwds_prev;

    logic [7:0]  byte_count;
    logic [7:0]  wait_counter;
    logic [7:0]  write_count;
    logic [7:0]  read_count;
    logic [7:0]  done_counter;

    logic        dq_oe;
    logic [7:0]  dq_o;
    logic        rwds_oe;
    logic        rwds_o;
    logic        cs_n_c;
    logic        capture;
    state_t      data_state;

    hyperram_ca_encode u_ca_encode (
        .write_enable (write_enable),
        .address      (address),
        .ca           (ca_word)
    );

    assign dq   = dq_oe   ? dq_o   : 'z;
    assign rwds = rwds_oe ? rwds_o : 1'bz;
    assign ck   = ck_q;
    assign cs_n = cs_n_c;
    assign busy = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Next state and pin drive
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        dq_oe      = 1'b0;
        dq_o       = '0;
        rwds_oe    = 1'b0;
        rwds_o     = 1'b0;
        cs_n_c     = 1'b1;
        capture    = 1'b0;
        data_state = we_q ? ST_WDATA : ST_RDATA;

        case (state)
            ST_IDLE: begin
                if (transaction_begin)
                    next_state = ST_CA;
            end
            ST_CA: begin
                cs_n_c = 1'b0;
                dq_oe  = 1'b1;
                dq_o   = ca_shift[47:40];
                if (byte_count == 8'(CA_BYTES - 1))
                    next_state = (wait_latency == '0) ? data_state : ST_LATENCY;
            end
            ST_LATENCY: begin
                cs_n_c = 1'b0;
                // >= keeps the wait bounded if wait_latency is lowered mid-wait
                if ((wait_counter + 8'd1) >= {2'b00, wait_latency})
                    next_state = data_state;
            end
            ST_WDATA: begin
                cs_n_c  = 1'b0;
                dq_oe   = 1'b1;
                dq_o    = wdata_shift[31:24];
                rwds_oe = 1'b1;
                rwds_o  = ~mask_shift[3];
                if (write_count == 8'(DATA_BYTES - 1))
                    next_state = ST_HOLD;
            end
            ST_RDATA: begin
                cs_n_c  = 1'b0;
                // strobe mode: a byte is valid on every rwds transition
                capture = timed_read | (rwds != rwds_prev);
                if (capture && (read_count == 8'(DATA_BYTES - 1)))
                    next_state = ST_HOLD;
            end
            ST_HOLD: begin
                cs_n_c     = 1'b0;
                next_state = (done_latency == '0) ? ST_IDLE : ST_RECOVER;
            end
            ST_RECOVER: begin
                if ((done_counter + 8'd1) >= {2'b00, done_latency})
                    next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ca_shift     <= '0;
            wdata_shift  <= '0;
            mask_shift   <= '0;
            rdata_shift  <= '0;
            we_q         <= 1'b0;
            ck_q         <= 1'b0;
            rwds_prev    <= 1'b0;
            byte_count   <= '0;
            wait_counter <= '0;
            write_count  <= '0;
            read_count   <= '0;
            done_counter <= '0;
            data_in      <= '0;
            done         <= 1'b0;
        end else begin
            state     <= next_state;
            rwds_prev <= rwds;
            done      <= 1'b0;
            // ck starts low on the first CA byte and is parked low outside the bus phases
            ck_q      <= (bus_active(state) && bus_active(next_state)) ? ~ck_q : 1'b0;

            case (state)
                ST_IDLE: begin
                    if (transaction_begin) begin
                        ca_shift     <= ca_word;
                        wdata_shift  <= data_out;
                        mask_shift   <= write_mask;
                        we_q         <= write_enable;
                        rdata_shift  <= '0;
                        byte_count   <= '0;
                        wait_counter <= '0;
                        write_count  <= '0;
                        read_count   <= '0;
                        done_counter <= '0;
                    end
                end
                ST_CA: begin
                    ca_shift   <= {ca_shift[39:0], 8'h00};
                    byte_count <= byte_count + 8'd1;
                end
                ST_LATENCY: begin
                    wait_counter <= wait_counter + 8'd1;
                end
                ST_WDATA: begin
                    wdata_shift <= {wdata_shift[23:0], 8'h00};
                    mask_shift  <= {mask_shift[2:0], 1'b0};
                    write_count <= write_count + 8'd1;
                end
                ST_RDATA: begin
                    if (capture) begin
                        rdata_shift <= {rdata_shift[23:0], dq};
                        read_count  <= read_count + 8'd1;
                    end
                end
                ST_RECOVER: begin
                    done_counter <= done_counter + 8'd1;
                end
                default: ;
            endcase

            if ((state != ST_IDLE) && (next_state == ST_IDLE)) begin
                done <= 1'b1;
                if (!we_q)
                    data_in <= rdata_shift;
            end
        end
    end

`ifdef HYPERRAM_FORMAL_EN
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state));
    a_idle_pins: assert property (@(posedge clk) disable iff (rst)
        (state == ST_IDLE) |-> (cs_n && !dq_oe && !rwds_oe));
    a_ck_low: assert property (@(posedge clk) disable iff (rst) cs_n |-> !ck);
    a_read_cnt: assert property (@(posedge clk) disable iff (rst)
        read_count <= 8'(DATA_BYTES));
    a_write_cnt: assert property (@(posedge clk) disable iff (rst)
        write_count <= 8'(DATA_BYTES));
    c_full_write: cover property (@(posedge clk) disable iff (rst)
        (state == ST_HOLD) && we_q && (write_count == 8'(DATA_BYTES)));
    c_full_read: cover property (@(posedge clk) disable iff (rst)
        (state == ST_HOLD) && !we_q && (read_count == 8'(DATA_BYTES)));
`else
    // no embedded checks in this build
`endif

endmodule

// File: tb/tb_hyperram_ctrl.sv
module tb_hyperram_ctrl;

    logic        clk;
    logic        rst;
    logic        transaction_begin;
    logic        write_enable;
    logic [31:0] address;
    logic [3:0]  write_mask;
    logic [31:0] data_out;
    logic [5:0]  wait_latency;
    logic [5:0]  done_latency;
    logic        timed_read;
    wire  [7:0]  dq;
    wire         rwds;
    logic        ck;
    logic        cs_n;
    logic [31:0] data_in;
    logic        busy;
    logic        done;

    logic [7:0]  tb_dq;
    logic        tb_dq_oe;
    logic        tb_rwds;
    logic        tb_rwds_oe;

    int vectors;
    int miscompares;

    assign dq   = tb_dq_oe   ? tb_dq   : 8'bz;
    assign rwds = tb_rwds_oe ? tb_rwds : 1'bz;

    hyperram_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .transaction_begin (transaction_begin),
        .write_enable      (write_enable),
        .address           (address),
        .write_mask        (write_mask),
        .data_out          (data_out),
        .wait_latency      (wait_latency),
        .done_latency      (done_latency),
        .timed_read        (timed_read),
        .dq                (dq),
        .rwds              (rwds),
        .ck                (ck),
        .cs_n              (cs_n),
        .data_in           (data_in),
        .busy              (busy),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a transaction; returns with the first CA cycle (k=0) visible.
    task automatic start(input logic we, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, input logic [5:0] wl, input logic [5:0] dl,
                         input logic tr);
        write_enable      = we;
        address           = a;
        write_mask        = m;
        data_out          = d;
        wait_latency      = wl;
        done_latency      = dl;
        timed_read        = tr;
        transaction_begin = 1'b1;
        tick();
        transaction_begin = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n got %b exp 1", cs_n); end
        vectors++;
        if (ck !== 1'b0) begin miscompares++; $display("FAIL reset_ck got %b exp 0", ck); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b exp 0", done); end
        vectors++;
        if (data_in !== 32'h0) begin miscompares++; $display("FAIL reset_data_in got %h exp 0", data_in); end
        rst = 1'b0;
        tick();
    endtask

    // 0xCCCCDDDD @0x12345678, mask F, wait 4, done 2; also pokes inputs mid-flight.
    task automatic test_write_basic();
        logic [7:0] exp_ca [0:5];
        logic [7:0] exp_wd [0:3];
        exp_ca = '{8'h22, 8'h46, 8'h8A, 8'hCF, 8'h00, 8'h00};
        exp_wd = '{8'hCC, 8'hCC, 8'hDD, 8'hDD};
        tb_rwds_oe = 1'b0;
        tb_dq_oe   = 1'b0;
        start(1'b1, 32'h1234_5678, 4'hF, 32'hCCCC_DDDD, 6'd4, 6'd2, 1'b1);
        for (int k = 0; k <= 18; k++) begin
            // late input changes and a request while busy must not disturb this write
            if (k == 1) begin data_out = 32'h0123_4567; address = 32'hFFFF_FFFF; write_mask = 4'h0; end
            transaction_begin = (k == 3);
            if (k < 6) begin
                vectors++;
                if (dq !== exp_ca[k]) begin miscompares++; $display("FAIL wr_ca k=%0d got %h exp %h", k, dq, exp_ca[k]); end
            end
            if (k >= 10 && k <= 13) begin
                vectors++;
                if (dq !== exp_wd[k-10]) begin miscompares++; $display("FAIL wr_dq k=%0d got %h exp %h", k, dq, exp_wd[k-10]); end
                vectors++;
                if (rwds !== 1'b0) begin miscompares++; $display("FAIL wr_rwds k=%0d got %b exp 0", k, rwds); end
            end
            vectors++;
            if (cs_n !== (k > 14)) begin miscompares++; $display("FAIL wr_cs_n k=%0d got %b exp %b", k, cs_n, (k > 14)); end
            vectors++;
            if (busy !== (k < 17)) begin miscompares++; $display("FAIL wr_busy k=%0d got %b exp %b", k, busy, (k < 17)); end
            vectors++;
            if (done !== (k == 17)) begin miscompares++; $display("FAIL wr_done k=%0d got %b exp %b", k, done, (k == 17)); end
            vectors++;
            if (ck !== ((k < 14) ? logic'(k % 2) : 1'b0)) begin
                miscompares++; $display("FAIL wr_ck k=%0d got %b", k, ck);
            end
            tick();
        end
        transaction_begin = 1'b0;
        tb_rwds_oe = 1'b1;
        tb_rwds    = 1'b0;
    endtask

    task automatic test_read_timed();
        logic [7:0] exp_ca [0:5];
        logic [7:0] rd [0:3];
        exp_ca = '{8'hA2, 8'h46, 8'h8A, 8'hCF, 8'h00, 8'h00};
        rd     = '{8'h11, 8'h22, 8'h33, 8'h44};
        tb_rwds_oe = 1'b1;
        tb_rwds    = 1'b0;
        start(1'b0, 32'h1234_5678, 4'hF, 32'h0, 6'd4, 6'd2, 1'b1);
        for (int k = 0; k <= 18; k++) begin
            tb_dq_oe = (k >= 10 && k <= 13);
            tb_dq    = (k >= 10 && k <= 13) ? rd[k-10] : 8'h00;
            if (k < 6) begin
                vectors++;
                if (dq !== exp_ca[k]) begin miscompares++; $display("FAIL rd_ca k=%0d got %h exp %h", k, dq, exp_ca[k]); end
            end
            if (k == 14 || k == 15) begin
                vectors++;
                if (cs_n !== (k == 15)) begin miscompares++; $display("FAIL rd_cs_n k=%0d got %b", k, cs_n); end
            end
            if (k >= 16) begin
                vectors++;
                if (done !== (k == 17)) begin miscompares++; $display("FAIL rd_done k=%0d got %b exp %b", k, done, (k == 17)); end
            end
            if (k == 17) begin
                vectors++;
                if (data_in !== 32'h1122_3344) begin miscompares++; $display("FAIL rd_data got %h exp 11223344", data_in); end
            end
            tick();
        end
        tb_dq_oe = 1'b0;
    endtask

    // rwds idle for 4 data cycles, then toggles every 2nd cycle; dq = 0x50+k
    task automatic test_read_strobe();
        tb_rwds_oe = 1'b1;
        tb_rwds    = 1'b0;
        start(1'b0, 32'h1234_5678, 4'hF, 32'h0, 6'd4, 6'd2, 1'b0);
        for (int k = 0; k <= 25; k++) begin
            tb_dq_oe = (k >= 10 && k <= 21);
            tb_dq    = 8'(8'h50 + k);
            tb_rwds  = (k >= 14 && k <= 21) ? logic'(((k - 14) / 2) % 2 == 0) : 1'b0;
            if (k == 13 || k == 19 || k == 23) begin
                vectors++;
                if (busy !== 1'b1) begin miscompares++; $display("FAIL st_busy k=%0d got %b exp 1", k, busy); end
            end
            if (k == 20 || k == 21 || k == 22) begin
                vectors++;
                if (cs_n !== (k == 22)) begin miscompares++; $display("FAIL st_cs_n k=%0d got %b exp %b", k, cs_n, (k == 22)); end
            end
            if (k == 21) begin
                vectors++;
                if (ck !== 1'b0) begin miscompares++; $display("FAIL st_hold_ck got %b exp 0", ck); end
            end
            if (k == 24) begin
                vectors++;
                if (done !== 1'b1) begin miscompares++; $display("FAIL st_done got %b exp 1", done); end
                vectors++;
                if (data_in !== 32'h5E60_6264) begin miscompares++; $display("FAIL st_data got %h exp 5e606264", data_in); end
            end
            tick();
        end
        tb_dq_oe = 1'b0;
        tb_rwds  = 1'b0;
    endtask

    task automatic test_write_mask();
        logic [7:0] exp_wd [0:3];
        logic       exp_rw [0:3];
        exp_wd = '{8'hCC, 8'hCC, 8'hDD, 8'hDD};
        exp_rw = '{1'b1, 1'b0, 1'b1, 1'b0};
        tb_rwds_oe = 1'b0;
        start(1'b1, 32'h1234_5678, 4'b0101, 32'hCCCC_DDDD, 6'd4, 6'd2, 1'b1);
        for (int k = 0; k <= 17; k++) begin
            if (k >= 10 && k <= 13) begin
                vectors++;
                if (dq !== exp_wd[k-10]) begin miscompares++; $display("FAIL mk_dq k=%0d got %h exp %h", k, dq, exp_wd[k-10]); end
                vectors++;
                if (rwds !== exp_rw[k-10]) begin miscompares++; $display("FAIL mk_rwds k=%0d got %b exp %b", k, rwds, exp_rw[k-10]); end
            end
            tick();
        end
        tb_rwds_oe = 1'b1;
        tb_rwds    = 1'b0;
    endtask

    // wait 0 / done 0, address with nonzero column bits
    task automatic test_zero_latency();
        logic [7:0] exp_ca [0:5];
        logic [7:0] exp_wd [0:3];
        exp_ca = '{8'h20, 8'h00, 8'h00, 8'h02, 8'h00, 8'h05};
        exp_wd = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        tb_rwds_oe = 1'b0;
        start(1'b1, 32'h0000_0015, 4'hF, 32'hA1B2_C3D4, 6'd0, 6'd0, 1'b1);
        for (int k = 0; k <= 12; k++) begin
            if (k < 6) begin
                vectors++;
                if (dq !== exp_ca[k]) begin miscompares++; $display("FAIL zl_ca k=%0d got %h exp %h", k, dq, exp_ca[k]); end
            end else if (k < 10) begin
                vectors++;
                if (dq !== exp_wd[k-6]) begin miscompares++; $display("FAIL zl_dq k=%0d got %h exp %h", k, dq, exp_wd[k-6]); end
            end
            if (k >= 10) begin
                vectors++;
                if (cs_n !== (k > 10)) begin miscompares++; $display("FAIL zl_cs_n k=%0d got %b exp %b", k, cs_n, (k > 10)); end
                vectors++;
                if (done !== (k == 11)) begin miscompares++; $display("FAIL zl_done k=%0d got %b exp %b", k, done, (k == 11)); end
                vectors++;
                if (busy !== (k == 10)) begin miscompares++; $display("FAIL zl_busy k=%0d got %b exp %b", k, busy, (k == 10)); end
            end
            tick();
        end
        tb_rwds_oe = 1'b1;
        tb_rwds    = 1'b0;
    endtask

    // reset asserted in LATENCY (k=7, ck high) releases the bus immediately
    task automatic test_reset_mid();
        tb_rwds_oe = 1'b1;
        tb_rwds    = 1'b0;
        start(1'b0, 32'h1234_5678, 4'hF, 32'h0, 6'd4, 6'd2, 1'b1);
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (cs_n !== 1'b1) begin miscompares++; $display("FAIL rm_cs_n got %b exp 1", cs_n); end
        vectors++;
        if (ck !== 1'b0) begin miscompares++; $display("FAIL rm_ck got %b exp 0", ck); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy got %b exp 0", busy); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (done !== 1'b0) begin miscompares++; $display("FAIL rm_done k=%0d got %b exp 0", k, done); end
            tick();
        end
        test_read_timed();
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        rst               = 1'b1;
        transaction_begin = 1'b0;
        write_enable      = 1'b0;
        address           = '0;
        write_mask        = '0;
        data_out          = '0;
        wait_latency      = '0;
        done_latency      = '0;
        timed_read        = 1'b1;
        tb_dq             = '0;
        tb_dq_oe          = 1'b0;
        tb_rwds           = 1'b0;
        tb_rwds_oe        = 1'b1;

        test_reset();
        test_write_basic();
        test_read_timed();
        test_read_strobe();
        test_write_mask();
        test_zero_latency();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
